// File: rtl/dec_entry_to_snum.sv
// Decimal keypad entry: assembles BCD digit strobes into a signed 8-bit value (-128..127).
// Outputs are registered; live preview for the display path, one-cycle valid pulse on commit.
module dec_entry_to_snum #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       neg_toggle,
  input  logic       clear,
  input  logic       enter,
  output logic [7:0] value,
  output logic       value_valid,
  output logic [7:0] preview,
  output logic       err,
  output logic [1:0] digit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0]  MAX_CNT   = 2'(MAX_DIGITS);
  localparam logic [8:0]  MAG_MIN_N = 9'd128;

  state_t      state_q, state_d;
  logic [8:0]  mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  value_q, value_d;
  logic        vv_q, vv_d;
  logic [7:0]  preview_q, preview_d;
  logic        err_q, err_d;

  logic        digit_ok;
  logic [10:0] nm;
  logic [10:0] lim;
  logic [7:0]  signed_cur;
  logic [7:0]  signed_nxt;

  assign digit_ok = digit_valid && (digit <= 4'd9);

  // Range check runs on the full 11-bit product so a large entry can never wrap.
  assign nm  = (11'(mag_q) * 11'd10) + 11'(digit);
  assign lim = neg_q ? 11'd128 : 11'd127;

  // Two's complement of the low byte: mag=128 negated gives 8'h80, mag=0 stays 0.
  assign signed_cur = neg_q ? (~mag_q[7:0] + 8'd1) : mag_q[7:0];
  assign signed_nxt = neg_d ? (~mag_d[7:0] + 8'd1) : mag_d[7:0];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    vv_d    = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      mag_d   = '0;
      neg_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enter) begin
            state_d = ST_IDLE;
          end else if (neg_toggle) begin
            neg_d = ~neg_q;
          end else if (digit_ok) begin
            mag_d   = 9'(digit);
            cnt_d   = 2'd1;
            state_d = ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (enter) begin
            value_d = signed_cur;
            vv_d    = 1'b1;
            state_d = ST_DONE;
          end else if (neg_toggle) begin
            if (neg_q && (mag_q == MAG_MIN_N)) begin
              state_d = ST_ERROR;
            end else begin
              neg_d = ~neg_q;
            end
          end else if (digit_ok) begin
            if ((cnt_q == MAX_CNT) || (nm > lim)) begin
              state_d = ST_ERROR;
            end else begin
              mag_d = nm[8:0];
              cnt_d = cnt_q + 2'd1;
            end
          end
        end

        ST_DONE: begin
          if (enter) begin
            state_d = ST_DONE;
          end else if (neg_toggle) begin
            mag_d   = '0;
            neg_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (digit_ok) begin
            mag_d   = 9'(digit);
            neg_d   = 1'b0;
            cnt_d   = 2'd1;
            state_d = ST_ENTRY;
          end
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    err_d     = (state_d == ST_ERROR);
    preview_d = err_d ? 8'd0 : signed_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      value_q   <= '0;
      vv_q      <= 1'b0;
      preview_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      vv_q      <= vv_d;
      preview_q <= preview_d;
      err_q     <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = vv_q;
  assign preview     = preview_q;
  assign err         = err_q;
  assign digit_count = cnt_q;

endmodule
